// File: rtl/stream_switch_nxm_rr_if.sv
// AXI4-Stream bundle carrying N parallel ports, flattened per field
// (port i occupies slice i of every vector).
interface stream_switch_nxm_rr_if #(
  parameter int N      = 4,
  parameter int DATA_W = 512
);
  logic [N-1:0]            tvalid;
  logic [DATA_W*N-1:0]     tdata;
  logic [DATA_W/8*N-1:0]   tkeep;
  logic [N-1:0]            tlast;
  logic [16*N-1:0]         tuser_size;
  logic [16*N-1:0]         tuser_src;
  logic [16*N-1:0]         tuser_dst;
  logic [N-1:0]            tready;

  modport master (
    output tvalid, tdata, tkeep, tlast, tuser_size, tuser_src, tuser_dst,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast, tuser_size, tuser_src, tuser_dst,
    output tready
  );
endinterface

// File: rtl/stream_switch_nxm_rr.sv
// NUM_SRC x NUM_DST AXI4-Stream packet switch: routes by tuser_dst with
// packet-locked round-robin per output, one output register stage, drop counter.
module stream_switch_nxm_rr #(
  parameter int NUM_SRC = 4,
  parameter int NUM_DST = 4,
  parameter int DATA_W  = 512,
  parameter int DST_W   = (NUM_DST > 1) ? $clog2(NUM_DST) : 1
) (
  input  logic                   axis_aclk,
  input  logic                   mod_rstn,
  stream_switch_nxm_rr_if.slave  s_axis,
  stream_switch_nxm_rr_if.master m_axis,
  output logic [31:0]            drop_cnt
);

  localparam int          SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int          KEEP_W    = DATA_W / 8;
  localparam logic [15:0] DST_LIMIT = 16'(NUM_DST);

  typedef enum logic [1:0] {SRC_IDLE, SRC_ROUTE, SRC_DROP} src_state_t;
  typedef enum logic [1:0] {ARB_IDLE, ARB_LOCKED, ARB_GAP} arb_state_t;

  src_state_t         src_st      [NUM_SRC];
  src_state_t         src_st_nxt  [NUM_SRC];
  logic [DST_W-1:0]   src_dst     [NUM_SRC];
  logic [DST_W-1:0]   src_dst_nxt [NUM_SRC];
  logic [DST_W-1:0]   req_dst     [NUM_SRC];
  logic [NUM_SRC-1:0] req_vld;
  logic [NUM_SRC-1:0] s_ready;
  logic [NUM_SRC-1:0] s_fire;
  logic [NUM_SRC-1:0] drop_done;

  arb_state_t         arb_st     [NUM_DST];
  arb_state_t         arb_st_nxt [NUM_DST];
  logic [SRC_W-1:0]   owner      [NUM_DST];
  logic [SRC_W-1:0]   owner_nxt  [NUM_DST];
  logic [SRC_W-1:0]   ptr        [NUM_DST];
  logic [SRC_W-1:0]   ptr_nxt    [NUM_DST];
  logic [SRC_W-1:0]   gnt_idx    [NUM_DST];
  logic [NUM_DST-1:0] gnt_vld;
  logic [NUM_DST-1:0] can_load;
  logic [NUM_DST-1:0] out_fire;
  logic [31:0]        drop_nxt;

  // Routing request: first beat decodes the whole tuser_dst field, later beats use the latched index.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      req_vld[i] = 1'b0;
      req_dst[i] = src_dst[i];
      if (src_st[i] == SRC_IDLE && s_axis.tvalid[i] &&
          s_axis.tuser_dst[i*16 +: 16] < DST_LIMIT) begin
        req_vld[i] = 1'b1;
        req_dst[i] = s_axis.tuser_dst[i*16 +: DST_W];
      end else if (src_st[i] == SRC_ROUTE) begin
        req_vld[i] = s_axis.tvalid[i];
      end
    end
  end

  always_comb begin
    logic             found;
    logic [SRC_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned j = 0; j < NUM_DST; j++) begin
      gnt_vld[j]  = 1'b0;
      gnt_idx[j]  = '0;
      can_load[j] = !m_axis.tvalid[j] || m_axis.tready[j];
      found       = 1'b0;
      case (arb_st[j])
        ARB_LOCKED: begin
          if (req_vld[owner[j]] && req_dst[owner[j]] == DST_W'(j)) begin
            gnt_vld[j] = 1'b1;
            gnt_idx[j] = owner[j];
          end
        end
        ARB_IDLE: begin
          for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = SRC_W'((32'(ptr[j]) + k) % NUM_SRC);
            if (!found && req_vld[idx] && req_dst[idx] == DST_W'(j)) begin
              found      = 1'b1;
              gnt_vld[j] = 1'b1;
              gnt_idx[j] = idx;
            end
          end
        end
        default: ;
      endcase
      out_fire[j] = gnt_vld[j] && can_load[j] && mod_rstn;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      s_ready[i] = 1'b0;
      if (mod_rstn) begin
        if (src_st[i] == SRC_DROP) s_ready[i] = 1'b1;
        for (int unsigned j = 0; j < NUM_DST; j++) begin
          if (gnt_vld[j] && can_load[j] && gnt_idx[j] == SRC_W'(i)) s_ready[i] = 1'b1;
        end
      end
    end
    s_fire = s_axis.tvalid & s_ready;
  end

  assign s_axis.tready = s_ready;

  // An invalid destination moves to DROP without consuming; DROP then swallows every beat.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_st_nxt[i]  = src_st[i];
      src_dst_nxt[i] = src_dst[i];
      drop_done[i]   = 1'b0;
      case (src_st[i])
        SRC_IDLE: begin
          if (s_axis.tvalid[i]) begin
            if (!req_vld[i]) begin
              src_st_nxt[i] = SRC_DROP;
            end else if (s_fire[i] && !s_axis.tlast[i]) begin
              src_st_nxt[i]  = SRC_ROUTE;
              src_dst_nxt[i] = req_dst[i];
            end
          end
        end
        SRC_ROUTE: if (s_fire[i] && s_axis.tlast[i]) src_st_nxt[i] = SRC_IDLE;
        SRC_DROP: begin
          if (s_fire[i] && s_axis.tlast[i]) begin
            src_st_nxt[i] = SRC_IDLE;
            drop_done[i]  = 1'b1;
          end
        end
        default: src_st_nxt[i] = SRC_IDLE;
      endcase
    end
  end

  // Releasing a locked packet passes through GAP, leaving one idle cycle before the next grant.
  always_comb begin
    for (int unsigned j = 0; j < NUM_DST; j++) begin
      arb_st_nxt[j] = arb_st[j];
      owner_nxt[j]  = owner[j];
      ptr_nxt[j]    = ptr[j];
      case (arb_st[j])
        ARB_IDLE: begin
          if (out_fire[j]) begin
            ptr_nxt[j] = (gnt_idx[j] == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx[j] + 1'b1;
            if (!s_axis.tlast[gnt_idx[j]]) begin
              arb_st_nxt[j] = ARB_LOCKED;
              owner_nxt[j]  = gnt_idx[j];
            end
          end
        end
        ARB_LOCKED: if (out_fire[j] && s_axis.tlast[owner[j]]) arb_st_nxt[j] = ARB_GAP;
        default:    arb_st_nxt[j] = ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    logic [32:0] sum;
    sum = {1'b0, drop_cnt};
    for (int unsigned i = 0; i < NUM_SRC; i++) sum = sum + 33'(drop_done[i]);
    drop_nxt = sum[32] ? '1 : sum[31:0];
  end

  always_ff @(posedge axis_aclk) begin
    if (!mod_rstn) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        src_st[i]  <= SRC_IDLE;
        src_dst[i] <= '0;
      end
      for (int unsigned j = 0; j < NUM_DST; j++) begin
        arb_st[j] <= ARB_IDLE;
        owner[j]  <= '0;
        ptr[j]    <= '0;
      end
      m_axis.tvalid <= '0;
      drop_cnt      <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        src_st[i]  <= src_st_nxt[i];
        src_dst[i] <= src_dst_nxt[i];
      end
      for (int unsigned j = 0; j < NUM_DST; j++) begin
        arb_st[j] <= arb_st_nxt[j];
        owner[j]  <= owner_nxt[j];
        ptr[j]    <= ptr_nxt[j];
        if (out_fire[j])          m_axis.tvalid[j] <= 1'b1;
        else if (m_axis.tready[j]) m_axis.tvalid[j] <= 1'b0;
      end
      drop_cnt <= drop_nxt;
    end
  end

  always_ff @(posedge axis_aclk) begin
    for (int unsigned j = 0; j < NUM_DST; j++) begin
      if (out_fire[j]) begin
        m_axis.tdata[j*DATA_W +: DATA_W]  <= s_axis.tdata[32'(gnt_idx[j])*DATA_W +: DATA_W];
        m_axis.tkeep[j*KEEP_W +: KEEP_W]  <= s_axis.tkeep[32'(gnt_idx[j])*KEEP_W +: KEEP_W];
        m_axis.tlast[j]                   <= s_axis.tlast[gnt_idx[j]];
        m_axis.tuser_size[j*16 +: 16]     <= s_axis.tuser_size[32'(gnt_idx[j])*16 +: 16];
        m_axis.tuser_src[j*16 +: 16]      <= s_axis.tuser_src[32'(gnt_idx[j])*16 +: 16];
        m_axis.tuser_dst[j*16 +: 16]      <= s_axis.tuser_dst[32'(gnt_idx[j])*16 +: 16];
      end
    end
  end

endmodule

// File: tb/tb_stream_switch_nxm_rr.sv
// Directed bench for a 2x2, 32-bit stream_switch_nxm_rr: routing, RR, drop,
// backpressure, single-beat throughput and mid-packet reset.
module tb_stream_switch_nxm_rr;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] drop_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  int          k;
  int          got;
  logic        prev_stall;
  logic        fire_in;
  logic [31:0] prev_d;

  always #5 clk = ~clk;

  stream_switch_nxm_rr_if #(.N(2), .DATA_W(32)) s_if ();
  stream_switch_nxm_rr_if #(.N(2), .DATA_W(32)) m_if ();

  stream_switch_nxm_rr #(.NUM_SRC(2), .NUM_DST(2), .DATA_W(32)) dut (
    .axis_aclk (clk),
    .mod_rstn  (rstn),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int j, input logic v, input logic [31:0] d,
                         input logic l);
    chk({tag, "_v"}, 64'(m_if.tvalid[j]), 64'(v));
    if (v) begin
      chk({tag, "_d"}, 64'(m_if.tdata[j*32 +: 32]), 64'(d));
      chk({tag, "_l"}, 64'(m_if.tlast[j]), 64'(l));
    end
  endtask

  task automatic put(input int s, input logic v, input logic [31:0] d, input logic l,
                     input logic [15:0] dst);
    s_if.tvalid[s]              = v;
    s_if.tdata[s*32 +: 32]      = d;
    s_if.tkeep[s*4 +: 4]        = d[3:0];
    s_if.tlast[s]               = l;
    s_if.tuser_size[s*16 +: 16] = 16'h0100 + 16'(s);
    s_if.tuser_src[s*16 +: 16]  = 16'hA000 + 16'(s);
    s_if.tuser_dst[s*16 +: 16]  = dst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn        = 1'b0;
    s_if.tvalid = '0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = '0;
    s_if.tuser_size = '0; s_if.tuser_src = '0; s_if.tuser_dst = '0;
    m_if.tready = 2'b11;

    // Reset: a waiting source must not be accepted
    put(0, 1'b1, 32'h1111_0000, 1'b0, 16'd0);
    tick(); tick();
    #1;
    chk("rst_tready", 64'(s_if.tready), 64'(2'b00));
    chk("rst_mvalid", 64'(m_if.tvalid), 64'(2'b00));
    chk("rst_drop",   64'(drop_cnt), 64'd0);
    put(0, 1'b0, 32'h0, 1'b0, 16'd0);
    rstn = 1'b1;
    tick();

    // 1: three-beat packet src0 -> m1; later beats carry misleading tuser_dst
    put(0, 1'b1, 32'hA1A1_0001, 1'b0, 16'd1);
    #1; chk("t1_rdy", 64'(s_if.tready), 64'(2'b01));
    tick();
    chk_out("t1_b1", 1, 1'b1, 32'hA1A1_0001, 1'b0);
    chk("t1_m0_idle", 64'(m_if.tvalid[0]), 64'd0);
    chk("t1_size", 64'(m_if.tuser_size[31:16]), 64'h0100);
    chk("t1_src",  64'(m_if.tuser_src[31:16]),  64'hA000);
    chk("t1_dst",  64'(m_if.tuser_dst[31:16]),  64'd1);
    put(0, 1'b1, 32'hA1A1_0002, 1'b0, 16'd0);
    tick();
    chk_out("t1_b2", 1, 1'b1, 32'hA1A1_0002, 1'b0);
    chk("t1_b2_m0", 64'(m_if.tvalid[0]), 64'd0);
    put(0, 1'b1, 32'hA1A1_0003, 1'b1, 16'd7);
    tick();
    chk_out("t1_b3", 1, 1'b1, 32'hA1A1_0003, 1'b1);
    chk("t1_keep", 64'(m_if.tkeep[7:4]), 64'h3);
    put(0, 1'b0, 32'h0, 1'b0, 16'd0);
    tick();
    chk("t1_end", 64'(m_if.tvalid), 64'(2'b00));

    // 2: src0 and src1 both two-beat to m0; src0 wins, gap, then src1
    put(0, 1'b1, 32'hB000_0000, 1'b0, 16'd0);
    put(1, 1'b1, 32'hC000_0000, 1'b0, 16'd0);
    #1; chk("t2_rdy0", 64'(s_if.tready), 64'(2'b01));
    tick();
    chk_out("t2_b0", 0, 1'b1, 32'hB000_0000, 1'b0);
    put(0, 1'b1, 32'hB000_0001, 1'b1, 16'd0);
    #1; chk("t2_rdy1", 64'(s_if.tready), 64'(2'b01));
    tick();
    chk_out("t2_b1", 0, 1'b1, 32'hB000_0001, 1'b1);
    put(0, 1'b0, 32'h0, 1'b0, 16'd0);
    #1; chk("t2_gap_rdy", 64'(s_if.tready), 64'(2'b00));
    tick();
    chk_out("t2_gap", 0, 1'b0, 32'h0, 1'b0);
    #1; chk("t2_rdy2", 64'(s_if.tready), 64'(2'b10));
    tick();
    chk_out("t2_c0", 0, 1'b1, 32'hC000_0000, 1'b0);
    put(1, 1'b1, 32'hC000_0001, 1'b1, 16'd0);
    tick();
    chk_out("t2_c1", 0, 1'b1, 32'hC000_0001, 1'b1);
    put(1, 1'b0, 32'h0, 1'b0, 16'd0);
    tick();
    chk_out("t2_end", 0, 1'b0, 32'h0, 1'b0);
    // RR: src0 single beat moves the pointer, so src1 wins the next contest
    put(0, 1'b1, 32'hD000_0000, 1'b1, 16'd0);
    #1; chk("t2_rr_rdy0", 64'(s_if.tready), 64'(2'b01));
    tick();
    chk_out("t2_d0", 0, 1'b1, 32'hD000_0000, 1'b1);
    put(0, 1'b1, 32'hE000_0000, 1'b1, 16'd0);
    put(1, 1'b1, 32'hF000_0000, 1'b1, 16'd0);
    #1; chk("t2_rr_rdy1", 64'(s_if.tready), 64'(2'b10));
    tick();
    chk_out("t2_f0", 0, 1'b1, 32'hF000_0000, 1'b1);
    put(1, 1'b0, 32'h0, 1'b0, 16'd0);
    #1; chk("t2_rr_rdy2", 64'(s_if.tready), 64'(2'b01));
    tick();
    chk_out("t2_e0", 0, 1'b1, 32'hE000_0000, 1'b1);
    put(0, 1'b0, 32'h0, 1'b0, 16'd0);
    tick();

    // 3: four-beat packet to 0x0100 (low bits alias output 0) is dropped
    put(0, 1'b1, 32'hDEAD_0000, 1'b0, 16'h0100);
    tick();
    for (int b = 0; b < 4; b++) begin
      put(0, 1'b1, 32'hDEAD_0000 + 32'(b), (b == 3), 16'h0100);
      #1; chk("t3_rdy", 64'(s_if.tready[0]), 64'd1);
      tick();
      chk("t3_none", 64'(m_if.tvalid), 64'(2'b00));
      chk("t3_cnt", 64'(drop_cnt), (b == 3) ? 64'd1 : 64'd0);
    end
    put(0, 1'b0, 32'h0, 1'b0, 16'd0);
    tick();

    // 4: eight-beat src1 -> m0 with m0 tready toggling 1010
    k = 0; got = 0; prev_stall = 1'b0; prev_d = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      m_if.tready[0] = (c % 2 == 0);
      if (k < 8) put(1, 1'b1, 32'h4400_0000 + 32'(k), (k == 7), 16'd0);
      else       put(1, 1'b0, 32'h0, 1'b0, 16'd0);
      #1;
      if (prev_stall) chk("t4_hold", 64'({m_if.tvalid[0], m_if.tdata[31:0]}), 64'({1'b1, prev_d}));
      if (m_if.tvalid[0] && m_if.tready[0]) begin
        chk("t4_beat", 64'({m_if.tlast[0], m_if.tdata[31:0]}),
            64'({(got == 7), 32'h4400_0000 + 32'(got)}));
        got++;
      end
      prev_stall = m_if.tvalid[0] && !m_if.tready[0];
      prev_d     = m_if.tdata[31:0];
      fire_in    = s_if.tready[1] && s_if.tvalid[1];
      tick();
      if (fire_in) k++;
    end
    chk("t4_count", 64'(got), 64'd8);
    put(1, 1'b0, 32'h0, 1'b0, 16'd0);
    m_if.tready = 2'b11;
    tick(); tick();

    // 5: back-to-back single-beat packets on both outputs in parallel
    for (int p = 0; p < 4; p++) begin
      put(0, 1'b1, 32'h5000_0000 + 32'(p), 1'b1, 16'd0);
      put(1, 1'b1, 32'h6000_0000 + 32'(p), 1'b1, 16'd1);
      #1; chk("t5_rdy", 64'(s_if.tready), 64'(2'b11));
      tick();
      chk_out("t5_m0", 0, 1'b1, 32'h5000_0000 + 32'(p), 1'b1);
      chk_out("t5_m1", 1, 1'b1, 32'h6000_0000 + 32'(p), 1'b1);
    end
    put(0, 1'b0, 32'h0, 1'b0, 16'd0);
    put(1, 1'b0, 32'h0, 1'b0, 16'd0);
    tick();

    // 6: reset in the middle of a packet
    put(0, 1'b1, 32'h7000_0000, 1'b0, 16'd1);
    #1; chk("t6_rdy", 64'(s_if.tready[0]), 64'd1);
    tick();
    chk_out("t6_b0", 1, 1'b1, 32'h7000_0000, 1'b0);
    put(0, 1'b1, 32'h7000_0001, 1'b0, 16'd1);
    rstn = 1'b0;
    #1; chk("t6_rst_rdy", 64'(s_if.tready), 64'(2'b00));
    tick();
    chk("t6_mvalid", 64'(m_if.tvalid), 64'(2'b00));
    chk("t6_drop",   64'(drop_cnt), 64'd0);
    put(0, 1'b1, 32'h7100_0000, 1'b1, 16'd1);
    put(1, 1'b1, 32'h7200_0000, 1'b1, 16'd1);
    rstn = 1'b1;
    #1; chk("t6_ptr_rdy", 64'(s_if.tready), 64'(2'b01));
    tick();
    chk_out("t6_first", 1, 1'b1, 32'h7100_0000, 1'b1);
    put(0, 1'b0, 32'h0, 1'b0, 16'd0);
    #1; chk("t6_rdy1", 64'(s_if.tready), 64'(2'b10));
    tick();
    chk_out("t6_second", 1, 1'b1, 32'h7200_0000, 1'b1);
    put(1, 1'b0, 32'h0, 1'b0, 16'd0);
    tick();
    chk("t6_end", 64'(m_if.tvalid), 64'(2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
